ctrl_sram: RTL and testbench

Burst access controller that acts as the initiator side of the single-port synchronous `sram` bus (`CSram`, `Direc`, `Datain`, `LeerMem`, `EscrMem`, `Dataout`). It accepts a burst command from the datapath or a loader and issues one SRAM access per cycle over consecutive word addresses. Write data arrives through a valid/ready handshake and read data leaves through a valid strobe. It sits between the processor's memory stage and the 256×32 data SRAM.

---
 rtl/ctrl_sram.sv | 101 ++++++++++
 tb/tb_ctrl_sram.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_sram.sv
// Burst access controller driving the single-port synchronous sram bus.
// One SRAM access per cycle over consecutive word addresses.
module ctrl_sram (
  input  logic        clk,
  input  logic        reset,
  input  logic        inicio,
  input  logic        escribir,
  input  logic [7:0]  dir_base,
  input  logic [4:0]  longitud,
  input  logic [31:0] dato_wr,
  input  logic        dato_wr_valido,
  output logic        dato_wr_listo,
  output logic [31:0] dato_rd,
  output logic        dato_rd_valido,
  output logic        ocupado,
  output logic        fin,
  output logic        CSram,
  output logic        EscrMem,
  output logic        LeerMem,
  output logic [7:0]  Direc,
  output logic [31:0] Datain,
  input  logic [31:0] Dataout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ESCR = 2'd1,
    LEER = 2'd2
  } state_t;

  state_t      state;
  logic [7:0]  dir_act;
  logic [4:0]  restantes;
  logic        paso;

  // A burst word advances every read cycle, or on each valid write word
  assign paso = (state == LEER) ||
                ((state == ESCR) && dato_wr_valido);

  // Burst sequencing: capture command, walk addresses, flag completion
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      dir_act        <= '0;
      restantes      <= '0;
      dato_rd_valido <= 1'b0;
      fin            <= 1'b0;
    end else begin
      fin            <= 1'b0;
      dato_rd_valido <= (state == LEER);
      unique case (state)
        IDLE: begin
          if (inicio) begin
            dir_act   <= dir_base;
            restantes <= longitud;
            state     <= escribir ? ESCR : LEER;
          end
        end
        ESCR, LEER: begin
          if (paso) begin
            if (restantes == 5'd0) begin
              state <= IDLE;
              fin   <= 1'b1;
            end else begin
              dir_act   <= dir_act + 8'd1;
              restantes <= restantes - 5'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // SRAM strobes; reset masks them so nothing is written at the reset edge
  always_comb begin
    CSram         = 1'b0;
    EscrMem       = 1'b0;
    LeerMem       = 1'b0;
    dato_wr_listo = 1'b0;
    Datain        = '0;
    if (state == ESCR) begin
      Datain = dato_wr;
    end
    if (!reset) begin
      if (state == ESCR) begin
        dato_wr_listo = 1'b1;
        CSram         = dato_wr_valido;
        EscrMem       = dato_wr_valido;
      end else if (state == LEER) begin
        CSram   = 1'b1;
        LeerMem = 1'b1;
      end
    end
  end

  assign Direc   = dir_act;
  assign dato_rd = Dataout;
  assign ocupado = (state != IDLE);

endmodule

// File: tb/tb_ctrl_sram.sv
// Scoreboard bench for ctrl_sram with a behavioural 256x32 sram.
// Expected writes/reads are queued by stimulus and popped by a monitor.
module tb_ctrl_sram;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inicio = 1'b0;
  logic        escribir = 1'b0;
  logic [7:0]  dir_base = '0;
  logic [4:0]  longitud = '0;
  logic [31:0] dato_wr = '0;
  logic        dato_wr_valido = 1'b0;
  logic        dato_wr_listo;
  logic [31:0] dato_rd;
  logic        dato_rd_valido;
  logic        ocupado;
  logic        fin;
  logic        CSram;
  logic        EscrMem;
  logic        LeerMem;
  logic [7:0]  Direc;
  logic [31:0] Datain;
  logic [31:0] Dataout = '0;

  logic        mem_init = 1'b1;
  logic [31:0] mem [256];
  logic [31:0] shadow [256];

  logic [39:0] exp_wr [$];
  logic [31:0] exp_rd [$];

  int n_cmp = 0;
  int n_bad = 0;
  int rd_cnt = 0;
  int fin_cnt = 0;

  ctrl_sram dut (
    .clk(clk), .reset(reset), .inicio(inicio),
    .escribir(escribir), .dir_base(dir_base),
    .longitud(longitud), .dato_wr(dato_wr),
    .dato_wr_valido(dato_wr_valido),
    .dato_wr_listo(dato_wr_listo),
    .dato_rd(dato_rd), .dato_rd_valido(dato_rd_valido),
    .ocupado(ocupado), .fin(fin), .CSram(CSram),
    .EscrMem(EscrMem), .LeerMem(LeerMem),
    .Direc(Direc), .Datain(Datain), .Dataout(Dataout)
  );

  always #5 clk = ~clk;

  // Behavioural sram: registered read, write on select+enable
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE_0000 + i;
    end else begin
      if (CSram && EscrMem) mem[Direc] <= Datain;
      if (CSram && LeerMem) Dataout <= mem[Direc];
    end
  end

  task automatic check(input string nm,
                       input logic [39:0] act,
                       input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pop expected writes/reads whenever the DUT presents one
  always @(negedge clk) begin
    if (CSram && EscrMem) begin
      if (exp_wr.size() == 0)
        check("unexpected_write", {Direc, Datain}, 40'h0);
      else
        check("write", {Direc, Datain}, exp_wr.pop_front());
    end
    if (dato_rd_valido) begin
      rd_cnt++;
      if (exp_rd.size() == 0)
        check("unexpected_read", {8'h0, dato_rd}, 40'h0);
      else
        check("read", {8'h0, dato_rd}, {8'h0, exp_rd.pop_front()});
    end
    if (fin) fin_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic e, input logic [7:0] b,
                     input logic [4:0] l);
    inicio = 1'b1;
    escribir = e;
    dir_base = b;
    longitud = l;
    tick();
    inicio = 1'b0;
    check("busy_after_cmd", {39'h0, ocupado}, 40'h1);
  endtask

  task automatic wdata(input int n, input logic [15:0] pat,
                       input logic [31:0] d0, input logic [7:0] base);
    logic [7:0] a;
    a = base;
    for (int i = 0; i < n; i++) begin
      dato_wr_valido = pat[i];
      dato_wr = d0 + i;
      if (pat[i]) begin
        exp_wr.push_back({a, d0 + i});
        shadow[a] = d0 + i;
        a = a + 8'd1;
      end else begin
        #1;
        check("stall_cs", {39'h0, CSram}, 40'h0);
      end
      tick();
    end
    dato_wr_valido = 1'b0;
  endtask

  task automatic rburst(input logic [7:0] b, input logic [4:0] l);
    logic [7:0] a;
    cmd(1'b0, b, l);
    a = b;
    for (int i = 0; i <= int'(l); i++) begin
      exp_rd.push_back(shadow[a]);
      a = a + 8'd1;
    end
    for (int i = 0; i < int'(l); i++) tick();
    check("rd_fin_early", {39'h0, fin}, 40'h0);
    tick();
    check("rd_fin", {39'h0, fin}, 40'h1);
    check("rd_fin_valid", {39'h0, dato_rd_valido}, 40'h1);
    check("rd_idle", {39'h0, ocupado}, 40'h0);
  endtask

  initial begin
    int rd0;
    int fin0;
    for (int i = 0; i < 256; i++) shadow[i] = 32'hC0DE_0000 + i;
    inicio = 1'b1;
    escribir = 1'b1;
    dato_wr_valido = 1'b1;
    repeat (3) tick();
    check("rst_cs", {39'h0, CSram}, 40'h0);
    check("rst_we", {39'h0, EscrMem}, 40'h0);
    check("rst_listo", {39'h0, dato_wr_listo}, 40'h0);
    check("rst_busy", {39'h0, ocupado}, 40'h0);
    check("rst_fin", {39'h0, fin}, 40'h0);
    check("rst_direc", {32'h0, Direc}, 40'h0);
    check("rst_datain", {8'h0, Datain}, 40'h0);
    inicio = 1'b0;
    dato_wr_valido = 1'b0;
    reset = 1'b0;
    mem_init = 1'b0;
    tick();

    // Write burst 0x10..0x13, valid held high
    cmd(1'b1, 8'h10, 5'd3);
    wdata(4, 16'hF, 32'hA0, 8'h10);
    check("wr_fin", {39'h0, fin}, 40'h1);
    check("wr_idle", {39'h0, ocupado}, 40'h0);
    tick();

    // Read back
    rburst(8'h10, 5'd3);
    tick();

    // Stalled write across the address wrap
    cmd(1'b1, 8'hFE, 5'd2);
    wdata(5, 16'b11001, 32'hD0, 8'hFE);
    check("wrap_fin", {39'h0, fin}, 40'h1);
    tick();

    // Single-word read then back-to-back single write
    rburst(8'h05, 5'd0);
    cmd(1'b1, 8'h06, 5'd0);
    check("b2b_listo", {39'h0, dato_wr_listo}, 40'h1);
    wdata(1, 16'h1, 32'h66, 8'h06);
    check("b2b_fin", {39'h0, fin}, 40'h1);
    tick();
    rburst(8'hFE, 5'd8);
    tick();

    // inicio pulsed during a 32-word read is ignored
    rd0 = rd_cnt;
    fin0 = fin_cnt;
    cmd(1'b0, 8'h00, 5'd31);
    for (int i = 0; i < 32; i++) exp_rd.push_back(shadow[i]);
    repeat (3) tick();
    inicio = 1'b1;
    escribir = 1'b1;
    dir_base = 8'h80;
    tick();
    inicio = 1'b0;
    repeat (40) tick();
    check("busy_reads", 40'(rd_cnt - rd0), 40'd32);
    check("busy_fins", 40'(fin_cnt - fin0), 40'd1);

    // Reset after two of four writes
    cmd(1'b1, 8'h20, 5'd3);
    wdata(2, 16'h3, 32'hE0, 8'h20);
    fin0 = fin_cnt;
    reset = 1'b1;
    dato_wr_valido = 1'b1;
    dato_wr = 32'hE2;
    #1;
    check("rstmid_cs", {39'h0, CSram}, 40'h0);
    check("rstmid_we", {39'h0, EscrMem}, 40'h0);
    tick();
    reset = 1'b0;
    dato_wr_valido = 1'b0;
    check("rstmid_busy", {39'h0, ocupado}, 40'h0);
    check("rstmid_fin", {39'h0, fin}, 40'h0);
    check("rstmid_rv", {39'h0, dato_rd_valido}, 40'h0);
    check("rstmid_direc", {32'h0, Direc}, 40'h0);
    repeat (3) tick();
    check("rstmid_nofin", 40'(fin_cnt - fin0), 40'd0);
    rburst(8'h1F, 5'd4);
    repeat (3) tick();

    check("wr_queue_empty", 40'(exp_wr.size()), 40'd0);
    check("rd_queue_empty", 40'(exp_rd.size()), 40'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
